// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
//   through a single 1-bit full-subtract stage and a 1-bit borrow register.
//
// Parameters
//   WIDTH   operand/result width in bits (1..32)
//
// Ports
//   clk     system clock, rising-edge active
//   rst     asynchronous active-high reset
//   start   begin a subtraction (only looked at while idle)
//   a, b    minuend / subtrahend, captured on the accepting edge
//   bin     borrow-in, captured on the accepting edge
//   busy    high while an operation is in progress (SHIFT and DONE)
//   done    one-cycle pulse, diff/borrow valid
//   diff    a - b - bin modulo 2^WIDTH, held until the next start is accepted
//   borrow  borrow-out of the full WIDTH-bit subtraction
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   // One extra counter bit keeps WIDTH=1 legal (a zero-width counter otherwise).
   localparam int            CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_br;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic             r_busy;
   logic             r_done;

   logic             w_load;
   logic             w_shift;
   logic             w_last;
   logic             w_d;
   logic             w_br_next;
   logic [WIDTH-1:0] w_diff_next;

   // Full-subtract stage on the current LSBs of the operand shift registers.
   assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
   assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
   assign w_last    = (r_cnt == LAST_BIT);

   // Result enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
   always_comb begin
      w_diff_next            = r_diff >> 1;
      w_diff_next[WIDTH-1]   = w_d;
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_shift      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load       = 1'b1;
               w_state_next = SHIFT;
            end
         end
         SHIFT: begin
            w_shift = 1'b1;
            if (w_last) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_br     <= 1'b0;
         r_cnt    <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         // busy/done registered from the next state so they track r_state exactly.
         r_busy  <= (w_state_next != IDLE);
         r_done  <= (w_state_next == DONE);
         if (w_load) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
         end
         if (w_shift) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_br   <= w_br_next;
            r_cnt  <= r_cnt + CW'(1);
            r_diff <= w_diff_next;
            if (w_last) begin
               r_borrow <= w_br_next;
            end
         end
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign diff   = r_diff;
   assign borrow = r_borrow;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend, captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  subtrahend, captured on the accepting edge.
REQ-007 Port: bin  input  1  borrow-in, captured on the accepting edge.
REQ-008 Port: busy  output  1  high while an operation is in progress (SHIFT and DONE).
REQ-009 Port: done  output  1  one-cycle pulse; diff/borrow are valid.
REQ-010 Port: diff  output  WIDTH  result a - b - bin modulo 2^WIDTH.
REQ-011 Port: borrow  output  1  borrow-out of the full WIDTH-bit subtraction.

Function
REQ-012 The block SHALL compute a - b - bin bit-serially, LSB first, one bit per clock, using a single 1-bit full-subtract stage (diff_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)) and a 1-bit borrow register.
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE; any unused encoding SHALL return to IDLE on the next edge.
REQ-014 IDLE: start=1 at an edge -> load a and b into shift registers, load bin into the borrow register, clear bit counter, go to SHIFT; start=0 -> stay in IDLE.
REQ-015 SHIFT: each edge processes one bit, shifts the result bit into diff from the MSB end, updates the borrow register, and increments the counter.
REQ-016 SHIFT -> DONE on the edge that processes bit WIDTH-1 (exactly WIDTH edges in SHIFT).
REQ-017 DONE: done=1 for exactly one cycle, then IDLE on the next edge unconditionally.
REQ-018 Latency: with start accepted at edge 0, done SHALL be high during the cycle following edge WIDTH; the next start can be accepted at edge WIDTH+2.
REQ-019 diff and borrow SHALL hold their final values from DONE until the next start is accepted; during SHIFT they are not valid.
REQ-020 start asserted in SHIFT or DONE SHALL be ignored (not queued); a and b changes after the accepting edge SHALL have no effect.
REQ-021 Counter width SHALL be clog2(WIDTH)+1 bits, so WIDTH=1 works: one SHIFT edge, then DONE.
REQ-022 busy SHALL be a registered function of state (1 in SHIFT and DONE, 0 in IDLE); done SHALL be 1 only in DONE.
REQ-023 borrow=1 iff a < b + bin as unsigned integers.

Reset
REQ-024 rst=1 SHALL immediately, without a clock edge, force state IDLE, counter 0, shift registers 0, borrow register 0, diff 0, borrow 0, busy 0, done 0.
REQ-025 rst asserted mid-operation SHALL abort the operation with no done pulse; after release the block SHALL accept a new start on the first edge.
REQ-026 start high on the first edge after rst deasserts SHALL be accepted normally.

Verification
REQ-027 WIDTH=8: a=0x5A, b=0x3C, bin=0, start pulse -> done 9 cycles after the accepting edge, diff=0x1E, borrow=0.
REQ-028 WIDTH=8: a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow=1; then a=0x10, b=0x10, bin=1 -> diff=0xFF, borrow=1.
REQ-029 WIDTH=8: start held high continuously -> operations repeat every WIDTH+2 cycles; a start during SHIFT does not restart the count and does not create an extra done.
REQ-030 WIDTH=8: rst pulsed at cycle 4 of SHIFT -> all outputs 0 asynchronously, no done; next operation 0xFF-0x01 gives diff=0xFE, borrow=0.
REQ-031 WIDTH=1: all 8 combinations of a, b and bin -> diff/borrow match the full-subtractor truth table; done comes 2 cycles after start.
REQ-032 Random regression at WIDTH=16: 1000 operands -> {borrow,diff} equals (a - b - bin) mod 2^17 with borrow as the sign bit.
